// File: rtl/rr_arbiter_if.sv
// rr_arbiter_if: request/grant bundle between requesters and the round-robin arbiter.
interface rr_arbiter_if #(
  parameter int NUM_REQ = 5
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [IW-1:0]      gnt_idx_o;
  logic               gnt_valid_o;
  logic               revoke_o;
  modport master (output req_i, input gnt_o, gnt_idx_o, gnt_valid_o, revoke_o);
  modport slave  (input req_i, output gnt_o, gnt_idx_o, gnt_valid_o, revoke_o);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered one-hot grant.
// Define RR_ARBITER_HOLD_LIMIT_EN to build the hold-limit timer and revoke pulse.
module rr_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 16
) (
  input logic         clk_i,
  input logic         arst_i,
  rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, idx_q, idx_d, win_idx, win_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, cand;
  logic [IW:0]        pos;
  logic               revoke_q, revoke_d, win_found, keep, at_limit, owner_req;
  // The current grantee is masked so a release hands off to someone else at the same edge.
  assign cand      = bus.req_i & ~gnt_q;
  assign owner_req = (state_q == GRANT) && bus.req_i[idx_q];
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_q} + (IW+1)'(k);
      pos = (pos >= (IW+1)'(NUM_REQ)) ? pos - (IW+1)'(NUM_REQ) : pos;
      if (cand[pos]) begin
        win_found = 1'b1;
        win_idx   = pos[IW-1:0];
      end
    end
  end
  assign win_nxt  = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign keep     = owner_req && !at_limit;
  assign revoke_d = owner_req && at_limit;
  assign state_d  = (keep || win_found) ? GRANT : IDLE;
  assign idx_d    = (!keep && win_found) ? win_idx : idx_q;
  assign ptr_d    = (!keep && win_found) ? win_nxt : ptr_q;
  assign gnt_d    = keep ? gnt_q : (win_found ? NUM_REQ'(1) << win_idx : '0);
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      revoke_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      revoke_q <= revoke_d;
    end
  end
`ifdef RR_ARBITER_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  assign at_limit   = hold_cnt_q == CW'(MAX_HOLD - 1);
  assign hold_cnt_d = keep ? hold_cnt_q + 1'b1 : '0;
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign at_limit        = 1'b0;
`endif
  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.gnt_valid_o = (state_q == GRANT);
  assign bus.revoke_o    = revoke_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed and random checks of rr_arbiter against a behavioural model.
module tb_rr_arbiter;
  localparam int N  = 5;
  localparam int MH = 4;
`ifdef RR_ARBITER_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic arst = 1'b1;
  rr_arbiter_if #(.NUM_REQ(N)) bus();
  rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (.clk_i(clk), .arst_i(arst), .bus(bus));
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail  = 0;
  bit m_valid, m_rev;
  int m_idx, m_ptr, m_held;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] c, input int p);
    for (int k = 0; k < N; k++) if (c[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic model_reset();
    m_valid = 0; m_rev = 0; m_idx = 0; m_ptr = 0; m_held = 0;
  endtask
  task automatic model_grant(input int w);
    m_valid = 1; m_idx = w; m_ptr = (w + 1) % N; m_held = 1;
  endtask
  task automatic model_step(input logic [N-1:0] r);
    int w;
    bit force_rel;
    logic [N-1:0] c;
    m_rev = 0;
    if (!m_valid) begin
      w = pick(r, m_ptr);
      if (w >= 0) model_grant(w);
    end else begin
      force_rel = HOLD_EN && r[m_idx] && (m_held == MH);
      if (r[m_idx] && !force_rel) m_held++;
      else begin
        c = r;
        c[m_idx] = 1'b0;
        w = pick(c, m_ptr);
        m_rev = force_rel;
        if (w >= 0) model_grant(w);
        else m_valid = 0;
      end
    end
  endtask
  task automatic check_outs(input string tag);
    check({tag, ".gnt"}, bus.gnt_o, m_valid ? (32'd1 << m_idx) : 32'd0);
    check({tag, ".valid"}, bus.gnt_valid_o, m_valid);
    check({tag, ".revoke"}, bus.revoke_o, m_rev);
    if (m_valid) check({tag, ".idx"}, bus.gnt_idx_o, m_idx);
  endtask
  task automatic cycle(input logic [N-1:0] r, input string tag);
    @(negedge clk);
    bus.req_i = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_outs(tag);
  endtask
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    arst = 1'b1;
    bus.req_i = '0;
    #1;
    model_reset();
    check({tag, ".gnt"}, bus.gnt_o, 0);
    check({tag, ".valid"}, bus.gnt_valid_o, 0);
    check({tag, ".idx"}, bus.gnt_idx_o, 0);
    check({tag, ".revoke"}, bus.revoke_o, 0);
    @(negedge clk);
    arst = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time %0t exceeded required bound", $time);
    $fatal(1);
  end
  initial begin
    logic [N-1:0] r;
    bus.req_i = '0;
    model_reset();
    #12;
    check_outs("reset");
    @(negedge clk);
    arst = 1'b0;
    cycle('0, "idle");
    cycle('0, "idle");
    cycle(5'b00100, "single");
    check("single.gnt_const", bus.gnt_o, 5'b00100);
    check("single.idx_const", bus.gnt_idx_o, 2);
    cycle(5'b00100, "single_hold");
    async_reset("mid_grant_rst");
    cycle('0, "post_rst");
    cycle('0, "post_rst");
    cycle(5'b00100, "single2");
    cycle('0, "single_rel");
    check("single_rel.gnt_const", bus.gnt_o, 0);
    async_reset("rst2");
    for (int i = 0; i < 6; i++) begin
      r = (i == 0) ? 5'b11111 : 5'b11111 & ~(5'd1 << m_idx);
      cycle(r, "rr");
      check("rr_order", bus.gnt_idx_o, i % N);
      check("rr_nobubble", bus.gnt_valid_o, 1);
    end
    cycle('0, "rr_rel");
    cycle(5'b10000, "wrap_g4");
    check("wrap_g4.idx", bus.gnt_idx_o, 4);
    cycle(5'b00001, "wrap_rel");
    check("wrap_rel.idx", bus.gnt_idx_o, 0);
    cycle('0, "wrap_idle");
    cycle(5'b10001, "wrap_ptr");
    check("wrap_ptr.idx", bus.gnt_idx_o, 4);
    cycle('0, "pre_hold");
    if (HOLD_EN) begin
      for (int i = 0; i < 6; i++) begin
        cycle(5'b00010, "hold");
        check("hold.valid_seq", bus.gnt_valid_o, (i == 4) ? 0 : 1);
        check("hold.revoke_seq", bus.revoke_o, (i == 4) ? 1 : 0);
      end
      cycle('0, "hold_rel");
      cycle('0, "hold_idle");
      for (int i = 0; i < 12; i++) cycle(5'b00011, "hold_alt");
    end else begin
      for (int i = 0; i < 100; i++) begin
        cycle(5'b00010, "nohold");
        if (i == 0 || i == 99) begin
          check("nohold.gnt_const", bus.gnt_o, 5'b00010);
          check("nohold.rev_const", bus.revoke_o, 0);
        end
      end
    end
    cycle('0, "rand_start");
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) r = N'($urandom) & N'($urandom | $urandom);
      if ($urandom_range(6) == 0) r = r & ~(N'(1) << m_idx);
      if ($urandom_range(250) == 0) async_reset("rand_rst");
      cycle(r, "rand");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
